mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage boundary of the 5-stage MIPS32 core.
- Captures the M-stage instruction and result into the W-stage registers.
- Waits on the data-memory response for loads and aligns/extends load data.
- Decodes the W-stage write-destination class into forward_bus_W, which the M-stage forwarding controller consumes together with IR_W.

Parameters:
- RESET_PC, 32'hBFC0_0000, value loaded into PC_W on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- IR_M  input  32  M-stage instruction word.
- PC_M  input  32  M-stage PC.
- valid_M  input  1  M-stage slot holds a real instruction.
- alu_result_M  input  32  ALU result / memory address from M.
- flush_W  input  1  kill the instruction entering W; abandon any pending load.
- dm_rdata  input  32  data-memory read data.
- dm_data_ok  input  1  read data valid this cycle (one pulse per load request).
- stall_M  output  1  hold M and all upstream stages this cycle.
- IR_W  output  32  W-stage instruction word (0 = bubble).
- PC_W  output  32  W-stage PC.
- valid_W  output  1  W-stage slot valid.
- result_W  output  32  write-back data.
- forward_bus_W  output  3  {forward_rd_W, forward_rt_W, forward_31_W}.

Behaviour:
- Reset (async): IR_W=0, PC_W=RESET_PC, valid_W=0, result_W=0, FSM=IDLE. forward_bus_W=0 and stall_M=0 follow from that state.
- Load decode: opcode lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101. is_load_M = valid_M & load opcode.
- FSM states:
  - IDLE:
    - is_load_M & !dm_data_ok & !flush_W -> WAIT.
    - is_load_M & !dm_data_ok & flush_W -> DRAIN.
    - Otherwise stay in IDLE.
  - WAIT: dm_data_ok -> IDLE; flush_W & !dm_data_ok -> DRAIN.
  - DRAIN: discard the next dm_data_ok, then -> IDLE.
- stall_M is combinational: (IDLE|WAIT) & is_load_M & !dm_data_ok & !flush_W, or state==DRAIN. Zero-wait memory (dm_data_ok in the request cycle) gives no stall.
- Capture on each edge where stall_M=0:
  - IR_W <= flush_W ? 0 : IR_M.
  - valid_W <= valid_M & !flush_W.
  - PC_W <= PC_M.
  - result_W <= is_load_M ? aligned(dm_rdata) : alu_result_M.
- When stall_M=1, the W registers load a bubble: IR_W=0, valid_W=0, result_W unchanged.
- Alignment uses alu_result_M[1:0]:
  - lb/lbu: byte at lane addr[1:0], sign/zero-extended.
  - lh/lhu: halfword at addr[1] (0 = bits 15:0), sign/zero-extended.
  - lw: whole word. Misaligned addresses are excepted upstream and never reach this block valid.
- forward_bus_W decode of IR_W, all zero when valid_W=0:
  - [2] = opcode 000000, funct != 001000 (jr), rd != 0.
  - [1] = opcode in {addi, addiu, slti, sltiu, andi, ori, xori, lui, loads}.
  - [0] = opcode 000011 (jal).
  - jalr is covered by [2].
- A dm_data_ok pulse in IDLE with no load present is ignored.

Optional Feature:
- Macro MEMWB_TRACE_EN.
- Defined: extra outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0], registered with the W stage.
  - wen = 4'hF when valid_W and any forward_bus_W bit is set, else 0.
  - wnum = rd, rt or 31 per the decoded class.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (e.g. cpu_defs):
  - Opcode/funct constants (OP_SPECIAL, OP_JAL, OP_LB…OP_LHU, FN_JR).
  - Field ranges rs/rt/rd.
  - FSM state encoding IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - forward_bus bit indices.
- One natural sub-module: load_align (combinational; inputs opcode, addr[1:0], rdata; output 32-bit extended data).

Test Plan:
- addu $3,$1,$2 valid, no stall, alu_result_M=0x1234 -> next cycle IR_W=IR_M, result_W=0x1234, forward_bus_W=3'b100, stall_M=0.
- lb at addr 0x...01 with dm_rdata=0x0000_8000 and dm_data_ok in the same cycle -> no stall; result_W=0xFFFF_FF80, forward_bus_W=3'b010.
- lhu at addr 0x...02, dm_data_ok delayed 3 cycles, dm_rdata=0xBEEF_0000 -> stall_M high for 3 cycles, IR_W=0 bubbles during that time, then result_W=0x0000_BEEF.
- lw waiting, flush_W pulsed in cycle 2, dm_data_ok in cycle 4 -> state DRAIN with stall_M=1 until cycle 4; the response is discarded, valid_W=0, then IDLE.
- jal at PC 0x8000_0000 -> forward_bus_W=3'b001. jr $31 -> forward_bus_W=3'b000.
- reset asserted while in WAIT -> immediately IR_W=0, valid_W=0, PC_W=RESET_PC, stall_M=0, state IDLE.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_pkg
// Purpose  : Shared definitions for the MEM/WB pipeline boundary: MIPS32
//            opcode/funct constants, instruction field ranges, the load-wait
//            FSM state encoding and forward_bus bit positions.
// Revision : 1.0  initial release
// ============================================================================
package mem_wb_stage_pkg;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR      = 6'b001000;

    // Instruction field ranges
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    // Load-response FSM
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } wb_state_e;

    // forward_bus bit positions
    localparam int FWD_RD = 2;
    localparam int FWD_RT = 1;
    localparam int FWD_31 = 0;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load-data lane selection and sign/zero extension.
// Ports    : opcode_i [5:0]  load opcode (lb/lh/lw/lbu/lhu)
//            addr_i   [1:0]  low address bits selecting the byte/half lane
//            rdata_i  [31:0] raw data-memory word
//            data_o   [31:0] aligned, extended load result
// Revision : 1.0  initial release
// ============================================================================
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (opcode_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'd0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline boundary. Captures the M-stage instruction and
//            result into W, holds M while a load waits on the data memory,
//            aligns load data and decodes the W write-destination class.
// Ports    : clk, reset (async, active high)
//            IR_M, PC_M, valid_M, alu_result_M   M-stage inputs
//            flush_W                             kill instruction entering W
//            dm_rdata, dm_data_ok                data-memory response
//            stall_M                             hold M and upstream
//            IR_W, PC_W, valid_W, result_W       W-stage state
//            forward_bus_W                       {rd, rt, r31} write class
// Options  : MEMWB_TRACE_EN adds debug_wb_pc/rf_wen/rf_wnum/rf_wdata.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic        valid_M,
    input  logic [31:0] alu_result_M,
    input  logic        flush_W,
    input  logic [31:0] dm_rdata,
    input  logic        dm_data_ok,
    output logic        stall_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_W,
    output logic        valid_W,
    output logic [31:0] result_W,
    output logic [2:0]  forward_bus_W
`ifdef MEMWB_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    wb_state_e   state_q, state_d;
    logic [31:0] ir_w_q, pc_w_q, result_w_q;
    logic        valid_w_q;
    logic        is_load_m;
    logic [31:0] load_data;

    assign is_load_m = valid_M & is_load_op(IR_M[OP_HI:OP_LO]);

    load_align u_load_align (
        .opcode_i (IR_M[OP_HI:OP_LO]),
        .addr_i   (alu_result_M[1:0]),
        .rdata_i  (dm_rdata),
        .data_o   (load_data)
    );

    // A flushed load still owes one response; DRAIN swallows it so it cannot
    // be mistaken for the data of a later load.
    always_comb begin
        state_d = state_q;
        stall_M = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_load_m && !dm_data_ok) begin
                    state_d = flush_W ? S_DRAIN : S_WAIT;
                    stall_M = !flush_W;
                end
            end
            S_WAIT: begin
                if (dm_data_ok) begin
                    state_d = S_IDLE;
                end else if (flush_W) begin
                    state_d = S_DRAIN;
                end
                stall_M = is_load_m && !dm_data_ok && !flush_W;
            end
            S_DRAIN: begin
                stall_M = 1'b1;
                if (dm_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_w_q     <= 32'd0;
            pc_w_q     <= RESET_PC;
            valid_w_q  <= 1'b0;
            result_w_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (stall_M) begin
                // Bubble into W; result and PC keep their last values.
                ir_w_q    <= 32'd0;
                valid_w_q <= 1'b0;
            end else begin
                ir_w_q     <= flush_W ? 32'd0 : IR_M;
                valid_w_q  <= valid_M & !flush_W;
                pc_w_q     <= PC_M;
                result_w_q <= is_load_m ? load_data : alu_result_M;
            end
        end
    end

    assign IR_W     = ir_w_q;
    assign PC_W     = pc_w_q;
    assign valid_W  = valid_w_q;
    assign result_W = result_w_q;

    // Destination-class decode; jalr is a SPECIAL op and lands in the rd class.
    logic [5:0] op_w;
    always_comb begin
        op_w          = ir_w_q[OP_HI:OP_LO];
        forward_bus_W = 3'b000;
        if (valid_w_q) begin
            forward_bus_W[FWD_RD] = (op_w == OP_SPECIAL) &&
                                    (ir_w_q[FN_HI:FN_LO] != FN_JR) &&
                                    (ir_w_q[RD_HI:RD_LO] != 5'd0);
            forward_bus_W[FWD_RT] = (op_w == OP_ADDI)  || (op_w == OP_ADDIU) ||
                                    (op_w == OP_SLTI)  || (op_w == OP_SLTIU) ||
                                    (op_w == OP_ANDI)  || (op_w == OP_ORI)   ||
                                    (op_w == OP_XORI)  || (op_w == OP_LUI)   ||
                                    is_load_op(op_w);
            forward_bus_W[FWD_31] = (op_w == OP_JAL);
        end
    end

`ifdef MEMWB_TRACE_EN
    // Driven straight from the W registers, so these track the W stage.
    always_comb begin
        debug_wb_pc       = pc_w_q;
        debug_wb_rf_wdata = result_w_q;
        debug_wb_rf_wen   = (valid_w_q && (forward_bus_W != 3'b000)) ? 4'hF : 4'h0;
        debug_wb_rf_wnum  = 5'd0;
        if (forward_bus_W[FWD_RD]) begin
            debug_wb_rf_wnum = ir_w_q[RD_HI:RD_LO];
        end else if (forward_bus_W[FWD_RT]) begin
            debug_wb_rf_wnum = ir_w_q[RT_HI:RT_LO];
        end else if (forward_bus_W[FWD_31]) begin
            debug_wb_rf_wnum = 5'd31;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage: a table of single-cycle
//            vectors plus directed multi-cycle sequences for load waits,
//            flush-while-waiting and reset during a wait.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, PC_M, alu_result_M, dm_rdata;
    logic        valid_M, flush_W, dm_data_ok;
    logic        stall_M;
    logic [31:0] IR_W, PC_W, result_W;
    logic        valid_W;
    logic [2:0]  forward_bus_W;
`ifdef MEMWB_TRACE_EN
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .IR_M          (IR_M),
        .PC_M          (PC_M),
        .valid_M       (valid_M),
        .alu_result_M  (alu_result_M),
        .flush_W       (flush_W),
        .dm_rdata      (dm_rdata),
        .dm_data_ok    (dm_data_ok),
        .stall_M       (stall_M),
        .IR_W          (IR_W),
        .PC_W          (PC_W),
        .valid_W       (valid_W),
        .result_W      (result_W),
        .forward_bus_W (forward_bus_W)
`ifdef MEMWB_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] alu;
        logic        flush;
        logic [31:0] rdata;
        logic        ok;
        logic [31:0] exp_ir;
        logic        exp_valid;
        logic [31:0] exp_res;
        logic [2:0]  exp_fwd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic v,
                         input logic [31:0] alu, input logic fl,
                         input logic [31:0] rd, input logic ok);
        IR_M = ir; PC_M = pc; valid_M = v; alu_result_M = alu;
        flush_W = fl; dm_rdata = rd; dm_data_ok = ok;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              ir            pc            v  alu           fl rdata         ok  exp_ir        ev exp_res       fwd
        vecs[0]  = '{32'h0022_1821, 32'h8000_1000, 1, 32'h0000_1234, 0, 32'h0,        0, 32'h0022_1821, 1, 32'h0000_1234, 3'b100}; // addu
        vecs[1]  = '{32'h8005_0001, 32'h8000_1004, 1, 32'h0000_1001, 0, 32'h0000_8000, 1, 32'h8005_0001, 1, 32'hFFFF_FF80, 3'b010}; // lb lane1
        vecs[2]  = '{32'h0C00_0010, 32'h8000_0000, 1, 32'h8000_0008, 0, 32'h0,        0, 32'h0C00_0010, 1, 32'h8000_0008, 3'b001}; // jal
        vecs[3]  = '{32'h03E0_0008, 32'h8000_0008, 1, 32'h0000_0000, 0, 32'h0,        0, 32'h03E0_0008, 1, 32'h0000_0000, 3'b000}; // jr $31
        vecs[4]  = '{32'h2004_0005, 32'h8000_000C, 1, 32'h0000_0005, 0, 32'h0,        0, 32'h2004_0005, 1, 32'h0000_0005, 3'b010}; // addi
        vecs[5]  = '{32'h0040_F809, 32'h8000_0010, 1, 32'h8000_0014, 0, 32'h0,        0, 32'h0040_F809, 1, 32'h8000_0014, 3'b100}; // jalr
        vecs[6]  = '{32'h8C07_0000, 32'h8000_0014, 1, 32'h0000_2000, 0, 32'hDEAD_BEEF, 1, 32'h8C07_0000, 1, 32'hDEAD_BEEF, 3'b010}; // lw
        vecs[7]  = '{32'h8408_0002, 32'h8000_0018, 1, 32'h0000_2002, 0, 32'h8001_1234, 1, 32'h8408_0002, 1, 32'hFFFF_8001, 3'b010}; // lh hi
        vecs[8]  = '{32'h9009_0003, 32'h8000_001C, 1, 32'h0000_2003, 0, 32'hAB00_0000, 1, 32'h9009_0003, 1, 32'h0000_00AB, 3'b010}; // lbu lane3
        vecs[9]  = '{32'h0022_1821, 32'h8000_0020, 1, 32'h0000_5555, 1, 32'h0,        0, 32'h0,        0, 32'h0000_5555, 3'b000}; // flushed addu
        vecs[10] = '{32'h0022_1821, 32'h8000_0024, 1, 32'h0000_7777, 0, 32'hFFFF_FFFF, 1, 32'h0022_1821, 1, 32'h0000_7777, 3'b100}; // stray ok
        vecs[11] = '{32'h8C07_0000, 32'h8000_0028, 0, 32'h0000_3000, 0, 32'h0,        0, 32'h8C07_0000, 0, 32'h0000_3000, 3'b000}; // invalid lw
        vecs[12] = '{32'h0000_0000, 32'h8000_002C, 1, 32'h0000_0000, 0, 32'h0,        0, 32'h0000_0000, 1, 32'h0000_0000, 3'b000}; // nop
        vecs[13] = '{32'h8005_0002, 32'h8000_0030, 1, 32'h0000_0002, 0, 32'h00FF_0000, 1, 32'h8005_0002, 1, 32'hFFFF_FFFF, 3'b010}; // lb lane2
        vecs[14] = '{32'h9406_0000, 32'h8000_0034, 1, 32'h0000_0000, 0, 32'h1234_ABCD, 1, 32'h9406_0000, 1, 32'h0000_ABCD, 3'b010}; // lhu lo

        // Reset
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_IR_W",    IR_W,     32'h0);
        chk("rst_PC_W",    PC_W,     32'hBFC0_0000);
        chk("rst_valid_W", {31'd0, valid_W}, 32'd0);
        chk("rst_result",  result_W, 32'h0);
        chk("rst_fwd",     {29'd0, forward_bus_W}, 32'd0);
        chk("rst_stall",   {31'd0, stall_M}, 32'd0);
        reset = 1'b0;

        // Table vectors: single cycle, never stalling
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].ir, vecs[i].pc, vecs[i].valid, vecs[i].alu,
                  vecs[i].flush, vecs[i].rdata, vecs[i].ok);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_M}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_IR_W", i),   IR_W, vecs[i].exp_ir);
            chk($sformatf("v%0d_PC_W", i),   PC_W, vecs[i].pc);
            chk($sformatf("v%0d_valid", i),  {31'd0, valid_W}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_result", i), result_W, vecs[i].exp_res);
            chk($sformatf("v%0d_fwd", i),    {29'd0, forward_bus_W}, {29'd0, vecs[i].exp_fwd});
        end

        // lhu waiting three cycles for its data
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(32'h9406_0002, 32'h8000_2000, 1'b1, 32'h0000_2002, 1'b0, 32'h0, 1'b0);
            #1;
            chk($sformatf("lhu_wait%0d_stall", k), {31'd0, stall_M}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("lhu_wait%0d_IR_W", k),  IR_W, 32'h0);
            chk($sformatf("lhu_wait%0d_valid", k), {31'd0, valid_W}, 32'd0);
            chk($sformatf("lhu_wait%0d_res", k),   result_W, 32'h0000_ABCD);
        end
        @(negedge clk);
        drive(32'h9406_0002, 32'h8000_2000, 1'b1, 32'h0000_2002, 1'b0, 32'hBEEF_0000, 1'b1);
        #1;
        chk("lhu_done_stall", {31'd0, stall_M}, 32'd0);
        @(posedge clk);
        #1;
        chk("lhu_done_IR_W",   IR_W, 32'h9406_0002);
        chk("lhu_done_valid",  {31'd0, valid_W}, 32'd1);
        chk("lhu_done_result", result_W, 32'h0000_BEEF);
        chk("lhu_done_fwd",    {29'd0, forward_bus_W}, 32'd2);

        // lw waiting, flushed in cycle 2, response in cycle 4 is dropped
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(32'h8C07_0000, 32'h8000_3000, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0);
            #1;
            chk($sformatf("lwf_c%0d_stall", k), {31'd0, stall_M}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        drive(32'h8C07_0000, 32'h8000_3000, 1'b1, 32'h0000_2000, 1'b1, 32'h1111_1111, 1'b0);
        #1;
        chk("lwf_c2_stall", {31'd0, stall_M}, 32'd0);
        @(posedge clk);
        #1;
        chk("lwf_c2_IR_W",  IR_W, 32'h0);
        chk("lwf_c2_valid", {31'd0, valid_W}, 32'd0);
        @(negedge clk);
        drive(32'h0022_1821, 32'h8000_3004, 1'b1, 32'h0000_0042, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lwf_c3_stall", {31'd0, stall_M}, 32'd1);
        @(posedge clk);
        #1;
        chk("lwf_c3_valid", {31'd0, valid_W}, 32'd0);
        @(negedge clk);
        drive(32'h0022_1821, 32'h8000_3004, 1'b1, 32'h0000_0042, 1'b0, 32'h2222_2222, 1'b1);
        #1;
        chk("lwf_c4_stall", {31'd0, stall_M}, 32'd1);
        @(posedge clk);
        #1;
        chk("lwf_c4_valid", {31'd0, valid_W}, 32'd0);
        chk("lwf_c4_res",   result_W, 32'h1111_1111);
        @(negedge clk);
        drive(32'h0022_1821, 32'h8000_3004, 1'b1, 32'h0000_0042, 1'b0, 32'h0, 1'b0);
        #1;
        chk("lwf_c5_stall", {31'd0, stall_M}, 32'd0);
        @(posedge clk);
        #1;
        chk("lwf_c5_IR_W",  IR_W, 32'h0022_1821);
        chk("lwf_c5_res",   result_W, 32'h0000_0042);
        chk("lwf_c5_PC_W",  PC_W, 32'h8000_3004);

        // Reset while a load waits
        @(negedge clk);
        drive(32'h8C07_0000, 32'h8000_4000, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        valid_M = 1'b0;
        #1;
        chk("arst_IR_W",   IR_W, 32'h0);
        chk("arst_valid",  {31'd0, valid_W}, 32'd0);
        chk("arst_PC_W",   PC_W, 32'hBFC0_0000);
        chk("arst_result", result_W, 32'h0);
        chk("arst_stall",  {31'd0, stall_M}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // A flush with no load must leave the FSM idle (a waiting FSM would drain).
        drive(32'h0022_1821, 32'h8000_5000, 1'b1, 32'h0000_0099, 1'b1, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h0022_1821, 32'h8000_5004, 1'b1, 32'h0000_0098, 1'b0, 32'h0, 1'b0);
        #1;
        chk("arst_idle_stall", {31'd0, stall_M}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_idle_IR_W", IR_W, 32'h0022_1821);
        chk("arst_idle_res",  result_W, 32'h0000_0098);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
